// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write side: address/data widths,
// the write-request record used by the pipeline WB stage and the arbiter,
// and a one-hot register decoder used for the pending mask.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  // Write request record: {we, wa, wd}
  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] wa;
    logic [REG_DATA_W-1:0] wd;
  } wb_req_t;

  // One-hot decode of a register address
  function automatic logic [NUM_REGS-1:0] dec_addr(input logic [REG_ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] m;
    m    = '0;
    m[a] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_result_fifo: small circular buffer holding long-latency results that
// could not be written immediately. Pointers wrap modulo DEPTH, the count is
// one bit wider so full and empty are distinguishable. Entry addresses and
// occupancy flags are exported so the owner can build a per-register mask.
// The owner guarantees no push when full and no pop when empty; push and pop
// in the same cycle are allowed at any legal occupancy.
module wb_result_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           push,
  input  logic [REG_ADDR_W-1:0]          push_wa,
  input  logic [REG_DATA_W-1:0]          push_wd,
  input  logic                           pop,
  output logic [REG_ADDR_W-1:0]          head_wa,
  output logic [REG_DATA_W-1:0]          head_wd,
  output logic [PTR_W:0]                 count,
  output logic [PTR_W-1:0]               rd_ptr,
  output logic [DEPTH-1:0]               entry_valid,
  output logic [DEPTH*REG_ADDR_W-1:0]    entry_wa
);

  logic [REG_ADDR_W-1:0] r_wa [DEPTH];
  logic [REG_DATA_W-1:0] r_wd [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W:0]        r_count;

  // Storage, pointers and occupancy; a reset discards every buffered entry
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_wa[i] <= '0;
        r_wd[i] <= '0;
      end
    end else begin
      if (push) begin
        r_wa[r_wr_ptr] <= push_wa;
        r_wd[r_wr_ptr] <= push_wd;
        r_wr_ptr       <= r_wr_ptr + 1'b1;
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  // Entry i is live when its distance from the read pointer is below count
  always_comb begin
    entry_valid = '0;
    entry_wa    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_wa[i*REG_ADDR_W +: REG_ADDR_W] = r_wa[i];
      entry_valid[i] = ({1'b0, (PTR_W'(i) - r_rd_ptr)} < r_count);
    end
  end

  assign head_wa = r_wa[r_rd_ptr];
  assign head_wd = r_wd[r_rd_ptr];
  assign count   = r_count;
  assign rd_ptr  = r_rd_ptr;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges the pipeline writeback stream and the
// long-latency result stream onto the single register-file write port.
// Pipeline writes always win; long-latency results queue in a small FIFO
// and drain in free slots, or bypass straight through when nothing waits.
// A pending mask tells the hazard unit which registers have buffered
// results, and a stall request breaks starvation of the FIFO head.
//
// Long-latency handshake: a result transfers in a cycle where lu_valid and
// lu_ready are both high. lu_ready depends only on the registered FIFO count
// (high unless full), never on lu_valid or a same-cycle pop. While lu_ready
// is low the producer must hold lu_valid, lu_wa and lu_wd stable. A result
// targeting r0 is accepted and discarded.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   pipe_we,
  input  logic [REG_ADDR_W-1:0]  pipe_wa,
  input  logic [REG_DATA_W-1:0]  pipe_wd,
  input  logic                   lu_valid,
  output logic                   lu_ready,
  input  logic [REG_ADDR_W-1:0]  lu_wa,
  input  logic [REG_DATA_W-1:0]  lu_wd,
  output logic                   we3,
  output logic [REG_ADDR_W-1:0]  wa3,
  output logic [REG_DATA_W-1:0]  wd3,
  output logic [NUM_REGS-1:0]    pend_mask,
  output logic                   stall_req,
  output logic                   busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(STARVE_MAX + 1) + 1;
  localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [REG_ADDR_W-1:0]       w_head_wa;
  logic [REG_DATA_W-1:0]       w_head_wd;
  logic [PTR_W:0]              w_count;
  logic [PTR_W-1:0]            w_rd_ptr;
  logic [DEPTH-1:0]            w_entry_valid;
  logic [DEPTH*REG_ADDR_W-1:0] w_entry_wa;

  logic                        w_pipe_slot;
  logic                        w_accept;
  logic                        w_store;
  logic                        w_empty;
  logic                        w_push;
  logic                        w_pop;
  wb_req_t                     w_sel;
  logic [NUM_REGS-1:0]         w_pend_next;
  logic [CNT_W-1:0]            w_starve_next;

  wb_req_t                     r_wb;
  logic [NUM_REGS-1:0]         r_pend;
  logic                        r_stall;
  logic [CNT_W-1:0]            r_starve;

  wb_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push        (w_push),
    .push_wa     (lu_wa),
    .push_wd     (lu_wd),
    .pop         (w_pop),
    .head_wa     (w_head_wa),
    .head_wd     (w_head_wd),
    .count       (w_count),
    .rd_ptr      (w_rd_ptr),
    .entry_valid (w_entry_valid),
    .entry_wa    (w_entry_wa)
  );

  assign w_empty  = (w_count == '0);
  assign lu_ready = (w_count != COUNT_FULL);
  assign busy     = !w_empty;

  // Issue arbitration: pipeline, then FIFO head, then bypass, else idle
  always_comb begin
    w_pipe_slot = pipe_we && (pipe_wa != '0);
    w_accept    = lu_valid && lu_ready;
    w_store     = w_accept && (lu_wa != '0);
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_sel       = '0;
    if (w_pipe_slot) begin
      w_sel.we = 1'b1;
      w_sel.wa = pipe_wa;
      w_sel.wd = pipe_wd;
      w_push   = w_store;
    end else if (!w_empty) begin
      w_sel.we = 1'b1;
      w_sel.wa = w_head_wa;
      w_sel.wd = w_head_wd;
      w_pop    = 1'b1;
      w_push   = w_store;
    end else if (w_store) begin
      w_sel.we = 1'b1;
      w_sel.wa = lu_wa;
      w_sel.wd = lu_wd;
    end
  end

  // Pending mask after this edge: surviving entries plus the new push, so
  // duplicate targets keep their bit until the last copy leaves
  always_comb begin
    w_pend_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_entry_valid[i] && !(w_pop && (PTR_W'(i) == w_rd_ptr))) begin
        w_pend_next = w_pend_next | dec_addr(w_entry_wa[i*REG_ADDR_W +: REG_ADDR_W]);
      end
    end
    if (w_push) begin
      w_pend_next = w_pend_next | dec_addr(lu_wa);
    end
  end

  // Starvation count: grows while the head waits, saturates at the limit
  always_comb begin
    if (w_pop || w_empty) begin
      w_starve_next = '0;
    end else if (r_starve >= STARVE_LIM) begin
      w_starve_next = r_starve;
    end else begin
      w_starve_next = r_starve + 1'b1;
    end
  end

  // Registered write port, pending mask and stall request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wb     <= '0;
      r_pend   <= '0;
      r_stall  <= 1'b0;
      r_starve <= '0;
    end else begin
      r_wb     <= w_sel;
      r_pend   <= w_pend_next;
      r_starve <= w_starve_next;
      r_stall  <= (w_starve_next >= STARVE_LIM);
    end
  end

  assign we3       = r_wb.we;
  assign wa3       = r_wb.wa;
  assign wd3       = r_wb.wd;
  assign pend_mask = r_pend;
  assign stall_req = r_stall;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a table of single-cycle vectors walking
// through pipe-only, r0, bypass, contention/starvation and duplicate-target
// scenarios, then hand-written sequences for pointer wrap against a queue
// model and for reset in the middle of a burst.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int NV    = 20;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  logic        pipe_we, lu_valid, lu_ready, we3, stall_req, busy;
  logic [4:0]  pipe_wa, lu_wa, wa3;
  logic [31:0] pipe_wd, lu_wd, wd3, pend_mask;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .pipe_we   (pipe_we),
    .pipe_wa   (pipe_wa),
    .pipe_wd   (pipe_wd),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_wa     (lu_wa),
    .lu_wd     (lu_wd),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .pend_mask (pend_mask),
    .stall_req (stall_req),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rf [32];
  logic [36:0] exp_q[$];

  typedef struct {
    logic        pwe;
    logic [4:0]  pwa;
    logic [31:0] pwd;
    logic        lv;
    logic [4:0]  lwa;
    logic [31:0] lwd;
    logic        ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    logic [31:0] epend;
    logic        estall;
    logic        ebusy;
    logic        eready;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input int pwe, input int pwa, input int pwd,
                              input int lv, input int lwa, input int lwd,
                              input int ewe, input int ewa, input int ewd,
                              input int epend, input int estall,
                              input int ebusy, input int eready);
    vec_t v;
    v.pwe = 1'(pwe); v.pwa = 5'(pwa); v.pwd = 32'(pwd);
    v.lv  = 1'(lv);  v.lwa = 5'(lwa); v.lwd = 32'(lwd);
    v.ewe = 1'(ewe); v.ewa = 5'(ewa); v.ewd = 32'(ewd);
    v.epend = 32'(epend); v.estall = 1'(estall);
    v.ebusy = 1'(ebusy);  v.eready = 1'(eready);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver
  task automatic drive(input int pwe, input int pwa, input int pwd,
                       input int lv, input int lwa, input int lwd);
    pipe_we  = 1'(pwe);
    pipe_wa  = 5'(pwa);
    pipe_wd  = 32'(pwd);
    lu_valid = 1'(lv);
    lu_wa    = 5'(lwa);
    lu_wd    = 32'(lwd);
  endtask

  // One clock: flag hazard-protocol violations, advance, record commits
  task automatic tick();
    check("protocol pipe write to pending reg",
          32'(pipe_we && (pipe_wa != 5'd0) && pend_mask[pipe_wa]), 32'd0);
    @(posedge clk);
    #1;
    if (we3) rf[wa3] = wd3;
  endtask

  logic        m_ready, m_acc, m_store, m_ewe;
  logic [36:0] m_exp, got;
  logic [31:0] m_pend;
  logic [36:0] fq[$];
  int          k, c_pwe, c_lv, c_lwa, c_lwd;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    vecs[0]  = mk(1, 5, 'h1234, 0, 0, 0,       1, 5, 'h1234, 'h00, 0, 0, 1);
    vecs[1]  = mk(1, 0, 'hFFFF, 0, 0, 0,       0, 0, 0,      'h00, 0, 0, 1);
    vecs[2]  = mk(0, 0, 0,      1, 9, 'hDEAD,  1, 9, 'hDEAD, 'h00, 0, 0, 1);
    vecs[3]  = mk(0, 0, 0,      0, 0, 0,       0, 0, 0,      'h00, 0, 0, 1);
    vecs[4]  = mk(1, 1, 'hA0,   1, 3, 'h3333,  1, 1, 'hA0,   'h08, 0, 1, 1);
    vecs[5]  = mk(1, 1, 'hA1,   1, 4, 'h4444,  1, 1, 'hA1,   'h18, 0, 1, 0);
    vecs[6]  = mk(1, 1, 'hA2,   1, 6, 'h6666,  1, 1, 'hA2,   'h18, 0, 1, 0);
    vecs[7]  = mk(1, 1, 'hA3,   1, 6, 'h6666,  1, 1, 'hA3,   'h18, 0, 1, 0);
    vecs[8]  = mk(1, 1, 'hA4,   1, 6, 'h6666,  1, 1, 'hA4,   'h18, 1, 1, 0);
    vecs[9]  = mk(1, 1, 'hA5,   1, 6, 'h6666,  1, 1, 'hA5,   'h18, 1, 1, 0);
    vecs[10] = mk(0, 0, 0,      1, 6, 'h6666,  1, 3, 'h3333, 'h10, 0, 1, 1);
    vecs[11] = mk(0, 0, 0,      1, 6, 'h6666,  1, 4, 'h4444, 'h40, 0, 1, 1);
    vecs[12] = mk(0, 0, 0,      0, 0, 0,       1, 6, 'h6666, 'h00, 0, 0, 1);
    vecs[13] = mk(1, 2, 'hB0,   1, 7, 'h7001,  1, 2, 'hB0,   'h80, 0, 1, 1);
    vecs[14] = mk(1, 2, 'hB1,   1, 7, 'h7002,  1, 2, 'hB1,   'h80, 0, 1, 0);
    vecs[15] = mk(0, 0, 0,      0, 0, 0,       1, 7, 'h7001, 'h80, 0, 1, 1);
    vecs[16] = mk(0, 0, 0,      0, 0, 0,       1, 7, 'h7002, 'h00, 0, 0, 1);
    vecs[17] = mk(0, 0, 0,      0, 0, 0,       0, 0, 0,      'h00, 0, 0, 1);
    vecs[18] = mk(0, 0, 0,      1, 0, 'h1111,  0, 0, 0,      'h00, 0, 0, 1);
    vecs[19] = mk(1, 2, 'hC0,   1, 0, 'h2222,  1, 2, 'hC0,   'h00, 0, 0, 1);

    // Reset values
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst we3", 32'(we3), 32'd0);
    check("rst wa3", 32'(wa3), 32'd0);
    check("rst wd3", wd3, 32'd0);
    check("rst pend_mask", pend_mask, 32'd0);
    check("rst stall_req", 32'(stall_req), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst lu_ready", 32'(lu_ready), 32'd1);
    resetn = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].pwe, vecs[i].pwa, vecs[i].pwd, vecs[i].lv, vecs[i].lwa, vecs[i].lwd);
      tick();
      check($sformatf("v%0d we3", i), 32'(we3), 32'(vecs[i].ewe));
      if (vecs[i].ewe) begin
        check($sformatf("v%0d wa3", i), 32'(wa3), 32'(vecs[i].ewa));
        check($sformatf("v%0d wd3", i), wd3, vecs[i].ewd);
      end
      check($sformatf("v%0d pend_mask", i), pend_mask, vecs[i].epend);
      check($sformatf("v%0d stall_req", i), 32'(stall_req), 32'(vecs[i].estall));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].ebusy));
      check($sformatf("v%0d lu_ready", i), 32'(lu_ready), 32'(vecs[i].eready));
    end
    check("rf r5", rf[5], 32'h1234);
    check("rf r9", rf[9], 32'hDEAD);
    check("rf r6", rf[6], 32'h6666);
    check("rf r7 last datum", rf[7], 32'h7002);
    check("rf r0 untouched", rf[0], 32'd0);

    // Pointer wrap: fill, then stream results through for 8 cycles, drain
    k = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      c_pwe = (cyc < 2) ? 1 : 0;
      c_lv  = (cyc < 10) ? 1 : 0;
      c_lwa = 11 + (k % 3);
      c_lwd = 'hE0 + k;
      m_ready = (fq.size() < DEPTH);
      check($sformatf("wrap%0d lu_ready", cyc), 32'(lu_ready), 32'(m_ready));
      m_acc   = (c_lv != 0) && m_ready;
      m_store = m_acc && (c_lwa != 0);
      m_ewe   = 1'b1;
      if (c_pwe != 0) begin
        m_exp = {5'd10, 32'('hD0 + cyc)};
        if (m_store) fq.push_back({5'(c_lwa), 32'(c_lwd)});
      end else if (fq.size() != 0) begin
        m_exp = fq.pop_front();
        if (m_store) fq.push_back({5'(c_lwa), 32'(c_lwd)});
      end else if (m_store) begin
        m_exp = {5'(c_lwa), 32'(c_lwd)};
      end else begin
        m_ewe = 1'b0;
        m_exp = '0;
      end
      if (m_ewe) exp_q.push_back(m_exp);
      m_pend = '0;
      foreach (fq[j]) m_pend[fq[j][36:32]] = 1'b1;
      drive(c_pwe, 10, 'hD0 + cyc, c_lv, c_lwa, c_lwd);
      tick();
      check($sformatf("wrap%0d we3", cyc), 32'(we3), 32'(m_ewe));
      if (we3) begin
        if (exp_q.size() == 0) begin
          check($sformatf("wrap%0d unexpected write", cyc), 32'd1, 32'd0);
        end else begin
          got   = {wa3, wd3};
          m_exp = exp_q.pop_front();
          check($sformatf("wrap%0d wa3", cyc), 32'(got[36:32]), 32'(m_exp[36:32]));
          check($sformatf("wrap%0d wd3", cyc), got[31:0], m_exp[31:0]);
        end
      end
      check($sformatf("wrap%0d pend_mask", cyc), pend_mask, m_pend);
      if (m_acc) k++;
    end
    check("wrap all results issued", 32'(exp_q.size()), 32'd0);
    check("wrap results accepted", 32'(k), 32'd9);
    exp_q.delete();

    // Reset in the middle of a burst with two entries buffered
    drive(1, 1, 'hF0, 1, 20, 'h2000);
    tick();
    drive(1, 1, 'hF1, 1, 21, 'h2100);
    tick();
    check("burst pend_mask", pend_mask, 32'h0030_0000);
    check("burst lu_ready full", 32'(lu_ready), 32'd0);
    check("burst we3 before reset", 32'(we3), 32'd1);
    drive(1, 1, 'hF2, 1, 22, 'h2200);
    #2;
    resetn = 1'b0;
    #1;
    check("async rst we3", 32'(we3), 32'd0);
    check("async rst pend_mask", pend_mask, 32'd0);
    check("async rst lu_ready", 32'(lu_ready), 32'd1);
    check("async rst busy", 32'(busy), 32'd0);
    tick();
    check("rst hold we3", 32'(we3), 32'd0);
    check("rst hold stall_req", 32'(stall_req), 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    resetn = 1'b1;
    tick();
    check("post rst we3 (buffer lost)", 32'(we3), 32'd0);
    check("post rst busy", 32'(busy), 32'd0);
    check("post rst pend_mask", pend_mask, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
